// File: rtl/alu_share_arbiter.sv
// Purpose: shares one combinational ALU between two requesters using round-robin arbitration.
// Latency: accept at T, response valid at T+2; the block is free again one cycle after the response is taken.
// Backpressure: each request is held until its ready; the response is held stable until the granted rspN_ready is high.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] alu_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    // r_prio = 0 favours req0 when both are valid; r_gnt remembers who owns the op in flight
    logic              r_prio;
    logic              r_gnt;

    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [DATA_W-1:0] r_rsp_data;

    logic              w_win0;
    logic              w_win1;
    logic              w_accept;
    logic              w_rsp_take;

    // A lone valid requester always wins; on contention prio breaks the tie
    assign w_win0     = req0_valid & (~req1_valid | ~r_prio);
    assign w_win1     = req1_valid & (~req0_valid |  r_prio);
    assign w_accept   = (r_state == ST_IDLE) & (w_win0 | w_win1);
    assign w_rsp_take = (r_state == ST_RESP) & (r_gnt ? rsp1_ready : rsp0_ready);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> EXEC -> RESP -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (w_rsp_take) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Arbitration bookkeeping: winner recorded, priority handed to the other requester
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
            r_gnt  <= 1'b0;
        end else if (w_accept) begin
            r_gnt  <= w_win1;
            r_prio <= ~w_win1;
        end
    end

    // Operand registers toward the ALU, loaded from the winner on the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_op <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
        end else if (w_accept) begin
            if (w_win1) begin
                r_alu_op <= req1_op;
                r_alu_a  <= req1_a;
                r_alu_b  <= req1_b;
            end else begin
                r_alu_op <= req0_op;
                r_alu_a  <= req0_a;
                r_alu_b  <= req0_b;
            end
        end
    end

    // Result capture: the ALU output is sampled once, at the end of EXEC, and then held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data <= '0;
        end else if (r_state == ST_EXEC) begin
            r_rsp_data <= alu_result;
        end
    end

    // Output decode from state; ready is a single-cycle pulse only while IDLE and out of reset
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = ~rst & w_win0;
                req1_ready = ~rst & w_win1;
            end
            ST_EXEC: begin
                busy = 1'b1;
            end
            ST_RESP: begin
                busy       = 1'b1;
                rsp0_valid = ~r_gnt;
                rsp1_valid =  r_gnt;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign alu_op   = r_alu_op;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign rsp_data = r_rsp_data;
    assign alu_data = r_rsp_data;

endmodule
